fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 26 ++
 rtl/fnd_scan_ctrl_if.sv | 30 +++
 rtl/fnd_scan_ctrl_scan_timer.sv | 30 +++
 rtl/fnd_scan_ctrl.sv | 111 +++++++++++
 tb/tb_fnd_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_t    : FSM state encoding (IDLE / SHOW / BLANK)
//   NUM_DIGITS : number of multiplexed digits on the display
//   COM_OFF    : all digit commons off (commons are active-low)
//   com_for()  : active-low common pattern that lights digit 'pos' if enabled in 'mask'
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam logic [NUM_DIGITS-1:0] COM_OFF = 8'hFF;

  // A masked-off digit yields all commons high, so its slot stays dark
  // without changing the scan timing.
  function automatic logic [NUM_DIGITS-1:0] com_for(input logic [2:0] pos,
                                                    input logic [NUM_DIGITS-1:0] mask);
    logic [NUM_DIGITS-1:0] sel;
    sel = 8'h01 << pos;
    return ~(sel & mask);
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Scan-controller signal bundle.
//   i_en         : scan enable (display dark when low)
//   i_digit_mask : bit k = 1 lights digit k
//   o_pos        : digit select into the segment mux (7 = leftmost)
//   o_com        : active-low digit commons
//   o_blank      : all commons forced off
//   o_frame      : one-cycle pulse on the 0 -> 7 wrap
// Modports: master drives enable/mask and observes the scan outputs;
// slave is the controller itself.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic                  i_en;
  logic [NUM_DIGITS-1:0] i_digit_mask;
  logic [2:0]            o_pos;
  logic [NUM_DIGITS-1:0] o_com;
  logic                  o_blank;
  logic                  o_frame;

  modport master (
    output i_en, i_digit_mask,
    input  o_pos, o_com, o_blank, o_frame
  );

  modport slave (
    input  i_en, i_digit_mask,
    output o_pos, o_com, o_blank, o_frame
  );

endinterface

// File: rtl/fnd_scan_ctrl_scan_timer.sv
// Terminal-count timer for dwell and blank intervals.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : restart the count at 0 on the next edge
//   i_term       : terminal value (interval length - 1)
//   o_done       : cnt equals the terminal value this cycle
// The owner clears the timer on every state change and on o_done, so the
// count never runs past the terminal value.
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_done = (cnt_reg == i_term);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Scan controller for the 8-digit multiplexed seven-segment display.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_en, i_digit_mask in; o_pos, o_com, o_blank, o_frame out
// Lights one digit at a time for DWELL cycles, then holds all commons off
// for BLANK cycles while the digit select settles (BLANK = 0 skips the gap).
// All outputs are registered and computed from the next state, so they
// change on the same edge as the state they describe.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500,
  parameter int CNT_W  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  fnd_scan_ctrl_if.slave  bus
);

  localparam logic [2:0]       POS_LAST  = 3'(DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_TC  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_TC  = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam bit               HAS_BLANK = (BLANK > 0);

  state_t                state_reg, state_next;
  logic [2:0]            pos_reg, pos_next;
  logic [NUM_DIGITS-1:0] com_reg, com_next;
  logic                  blank_reg, blank_next;
  logic                  frame_reg, frame_next;

  logic                  done;
  logic                  timer_clear;
  logic [CNT_W-1:0]      timer_term;
  logic                  step;

  // Timer restarts on entry to each interval; IDLE and disable hold it at 0.
  assign timer_clear = !bus.i_en || (state_reg == ST_IDLE) || done;
  assign timer_term  = (state_reg == ST_BLANK) ? BLANK_TC : DWELL_TC;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (timer_clear),
    .i_term  (timer_term),
    .o_done  (done)
  );

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      pos_reg   <= POS_LAST;
      com_reg   <= COM_OFF;
      blank_reg <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      com_reg   <= com_next;
      blank_reg <= blank_next;
      frame_reg <= frame_next;
    end
  end

  // Next state
  always_comb begin
    state_next = state_reg;
    if (!bus.i_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_SHOW;
        ST_SHOW:  if (done && HAS_BLANK) state_next = ST_BLANK;
        ST_BLANK: if (done) state_next = ST_SHOW;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Next outputs. The digit select advances at the end of each dwell, so with
  // blanking it moves while the commons are already off.
  always_comb begin
    step       = bus.i_en && (state_reg == ST_SHOW) && done;
    pos_next   = step ? pos_reg - 3'd1 : pos_reg;
    frame_next = step && (pos_reg == 3'd0);
    com_next   = COM_OFF;
    blank_next = 1'b1;
    case (state_next)
      ST_SHOW: begin
        com_next   = com_for(pos_next, bus.i_digit_mask);
        blank_next = 1'b0;
      end
      ST_BLANK: begin
        com_next   = COM_OFF;
        blank_next = 1'b1;
      end
      default: begin
        // A disabled scan discards the partial frame and restarts at the left.
        pos_next   = POS_LAST;
        frame_next = 1'b0;
      end
    endcase
  end

  assign bus.o_pos   = pos_reg;
  assign bus.o_com   = com_reg;
  assign bus.o_blank = blank_reg;
  assign bus.o_frame = frame_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: dut_a uses DWELL=4/BLANK=2, dut_b DWELL=4/BLANK=0.
// Stimulus pushes the expected outputs for the coming edge into a queue per
// DUT; a monitor per DUT pops and compares after each rising edge.
module tb_fnd_scan_ctrl;

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] com;
    logic       blank;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnd_scan_ctrl_if ifa();
  fnd_scan_ctrl_if ifb();

  fnd_scan_ctrl #(.DIGITS(8), .DWELL(4), .BLANK(2), .CNT_W(16)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  fnd_scan_ctrl #(.DIGITS(8), .DWELL(4), .BLANK(0), .CNT_W(16)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  exp_t  qa[$];
  exp_t  qb[$];
  string na[$];
  string nb[$];
  int    total = 0;
  int    bad   = 0;

  int ta = 0;
  int tb = 0;
  bit runa = 0;
  bit runb = 0;

  // Digit shown at t cycles after leaving IDLE: each slot is d lit cycles
  // followed by b dark cycles, and the select already shows the next digit
  // during the dark cycles.
  function automatic int pos_at(input int d, input int b, input int t);
    int p, slot, w;
    p = d + b;
    slot = t / p;
    w = t % p;
    if (w < d) return 7 - (slot % 8);
    return 7 - ((slot + 1) % 8);
  endfunction

  function automatic exp_t tline(input int d, input int b, input int t, input logic [7:0] mask);
    exp_t e;
    int dig;
    logic [7:0] one;
    dig = pos_at(d, b, t);
    e.pos = 3'(dig);
    if ((t % (d + b)) < d) begin
      one = 8'h01 << dig;
      e.com = mask[dig] ? ~one : 8'hFF;
      e.blank = 1'b0;
    end else begin
      e.com = 8'hFF;
      e.blank = 1'b1;
    end
    e.frame = (t > 0) && (dig == 7) && (pos_at(d, b, t - 1) == 0);
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.pos = 3'd7;
    e.com = 8'hFF;
    e.blank = 1'b1;
    e.frame = 1'b0;
    return e;
  endfunction

  // Called at a falling edge once inputs are set; queues the outputs
  // expected after the next rising edge, then waits one cycle.
  task automatic tick(input string nm);
    exp_t e;
    if (rst || !ifa.i_en) begin
      runa = 0;
      e = idle_exp();
    end else begin
      if (!runa) begin
        runa = 1;
        ta = 0;
      end else begin
        ta++;
      end
      e = tline(4, 2, ta, ifa.i_digit_mask);
    end
    qa.push_back(e);
    na.push_back(nm);
    if (rst || !ifb.i_en) begin
      runb = 0;
      e = idle_exp();
    end else begin
      if (!runb) begin
        runb = 1;
        tb = 0;
      end else begin
        tb++;
      end
      e = tline(4, 0, tb, ifb.i_digit_mask);
    end
    qb.push_back(e);
    nb.push_back(nm);
    @(negedge clk);
  endtask

  task automatic check(input string dut, input string nm, input exp_t e,
                       input logic [2:0] pos, input logic [7:0] com,
                       input logic blank, input logic frame);
    exp_t got;
    got = '{pos: pos, com: com, blank: blank, frame: frame};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s_%s: got pos=%0d com=%h blank=%b frame=%b, want pos=%0d com=%h blank=%b frame=%b",
               dut, nm, pos, com, blank, frame, e.pos, e.com, e.blank, e.frame);
    end else begin
      $display("%s %-10s pos=%0d com=%h blank=%b frame=%b ok", dut, nm, pos, com, blank, frame);
    end
    total++;
    if ($countones(~com) > 1) begin
      bad++;
      $display("FAIL %s_%s_onehot: got com=%h, want at most one low bit", dut, nm, com);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      check("a", na.pop_front(), qa.pop_front(), ifa.o_pos, ifa.o_com, ifa.o_blank, ifa.o_frame);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (qb.size() > 0) begin
      check("b", nb.pop_front(), qb.pop_front(), ifb.o_pos, ifb.o_com, ifb.o_blank, ifb.o_frame);
    end
  end

  initial begin
    rst = 1'b1;
    ifa.i_en = 1'b1;
    ifa.i_digit_mask = 8'hFF;
    ifb.i_en = 1'b1;
    ifb.i_digit_mask = 8'hFF;
    @(negedge clk);
    repeat (2) tick("reset");
    rst = 1'b0;

    // Startup and two full frames (dut_b covers the no-gap case)
    repeat (100) tick("frame");

    // Digit 3 dark but still timed
    ifa.i_digit_mask = 8'b1111_0111;
    repeat (48) tick("mask");
    ifa.i_digit_mask = 8'hFF;

    // Drop enable mid-dwell on digit 4, then restart from digit 7
    for (int k = 0; k < 60; k++) begin
      if (runa && pos_at(4, 2, ta) == 4 && (ta % 6) == 1) break;
      tick("seek4");
    end
    ifa.i_en = 1'b0;
    tick("disable");
    tick("off");
    ifa.i_en = 1'b1;
    repeat (8) tick("restart");

    // Reset during a blank gap
    for (int k = 0; k < 60; k++) begin
      if (runa && (ta % 6) == 4) break;
      tick("seekblank");
    end
    rst = 1'b1;
    tick("rst_blank");
    tick("rst_hold");
    rst = 1'b0;
    repeat (10) tick("after_rst");

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
